// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides CPU-cycle strobes into quarter/half-frame clocks and frame IRQ.
// Latency: e_pulse/l_pulse/frame_irq are registered, visible one clk after the causing strobe.
// Backpressure: none; every apu_clk strobe is consumed, strobes may be spaced arbitrarily.
module apu_frame_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_clk,
  input  logic       wr_4017,
  input  logic [7:0] from_cpu,
  input  logic       rd_4015,
  output logic       e_pulse,
  output logic       l_pulse,
  output logic       frame_irq,
  output logic       mode_out
);

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] cyc;
  logic        parity;
  logic        mode;
  logic        pend_mode;
  logic        inhibit;
  logic [2:0]  dly;

  logic q_evt;
  logic h_evt;
  logic irq_evt;
  logic wrap;
  logic reload;
  logic inhibit_nxt;
  logic irq_set;
  logic irq_clr;

  // Decode the sequencer events from the current step count and active mode
  always_comb begin
    q_evt   = (cyc == 16'd7456) || (cyc == 16'd14912) || (cyc == 16'd22370) ||
              (mode ? (cyc == 16'd37280) : (cyc == 16'd29828));
    h_evt   = (cyc == 16'd14912) ||
              (mode ? (cyc == 16'd37280) : (cyc == 16'd29828));
    irq_evt = !mode && ((cyc == 16'd29827) || (cyc == 16'd29828) || (cyc == 16'd29829));
    wrap    = mode ? (cyc == 16'd37281) : (cyc == 16'd29829);
  end

  // Delay expiry, and IRQ set/clear qualification (a write that sets inhibit also masks a same-clk set)
  always_comb begin
    reload      = apu_clk && (state == PENDING) && !wr_4017 && (dly == 3'd1);
    inhibit_nxt = wr_4017 ? from_cpu[6] : inhibit;
    irq_set     = apu_clk && !reload && irq_evt && !inhibit_nxt;
    irq_clr     = rd_4015 || (wr_4017 && from_cpu[6]);
  end

  // Sequencer state, $4017 register, delayed reset and registered strobes/IRQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cyc       <= 16'd0;
      parity    <= 1'b0;
      mode      <= 1'b0;
      pend_mode <= 1'b0;
      inhibit   <= 1'b0;
      dly       <= 3'd0;
      e_pulse   <= 1'b0;
      l_pulse   <= 1'b0;
      frame_irq <= 1'b0;
    end else begin
      e_pulse <= 1'b0;
      l_pulse <= 1'b0;

      if (wr_4017) begin
        inhibit   <= from_cpu[6];
        pend_mode <= from_cpu[7];
        dly       <= parity ? 3'd4 : 3'd3;
        state     <= PENDING;
      end

      if (apu_clk) begin
        parity <= ~parity;
        if (reload) begin
          // The delayed reset replaces normal decode; entering 5-step mode clocks Q+H once
          cyc     <= 16'd0;
          mode    <= pend_mode;
          state   <= RUN;
          e_pulse <= pend_mode;
          l_pulse <= pend_mode;
        end else begin
          cyc     <= wrap ? 16'd0 : cyc + 16'd1;
          e_pulse <= q_evt;
          l_pulse <= h_evt;
          // A strobe landing on the write clk does not count toward the delay
          if ((state == PENDING) && !wr_4017) begin
            dly <= dly - 3'd1;
          end
        end
      end

      if (irq_set) begin
        frame_irq <= 1'b1;
      end else if (irq_clr) begin
        frame_irq <= 1'b0;
      end
    end
  end

  assign mode_out = mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer: table-driven frame cadence plus hand-written
// sequences for IRQ clear/set races, $4017 delay parity, inhibit and reset mid-delay.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       apu_clk = 1'b0;
  logic       wr_4017 = 1'b0;
  logic [7:0] from_cpu = 8'h00;
  logic       rd_4015 = 1'b0;
  logic       e_pulse;
  logic       l_pulse;
  logic       frame_irq;
  logic       mode_out;

  apu_frame_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .apu_clk   (apu_clk),
    .wr_4017   (wr_4017),
    .from_cpu  (from_cpu),
    .rd_4015   (rd_4015),
    .e_pulse   (e_pulse),
    .l_pulse   (l_pulse),
    .frame_irq (frame_irq),
    .mode_out  (mode_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    phase;
    string name;
    int    upto;   // strobe index (relative to phase base) after which outputs are compared
    bit    stb;    // 1: last step is a strobe, 0: an idle clk
    bit    rd;
    bit    e;
    bit    l;
    bit    irq;
    bit    md;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;
  int   sidx   = 0;
  int   base   = 0;
  int   e_cnt  = 0;
  int   l_cnt  = 0;
  bit   irq_seen = 1'b0;

  function automatic vec_t mk(input int p, input string n, input int u, input bit s,
                              input bit r, input bit e, input bit l, input bit i, input bit m);
    vec_t v;
    v.phase = p; v.name = n; v.upto = u; v.stb = s; v.rd = r;
    v.e = e; v.l = l; v.irq = i; v.md = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic strobe(input bit rd);
    apu_clk = 1'b1;
    rd_4015 = rd;
    @(posedge clk);
    #1;
    apu_clk = 1'b0;
    rd_4015 = 1'b0;
    sidx++;
    if (e_pulse) e_cnt++;
    if (l_pulse) l_cnt++;
    if (frame_irq) irq_seen = 1'b1;
  endtask

  task automatic idle(input bit rd, input bit wr, input logic [7:0] data);
    rd_4015  = rd;
    wr_4017  = wr;
    from_cpu = data;
    @(posedge clk);
    #1;
    rd_4015  = 1'b0;
    wr_4017  = 1'b0;
    from_cpu = 8'h00;
  endtask

  task automatic start_phase();
    base     = sidx;
    e_cnt    = 0;
    l_cnt    = 0;
    irq_seen = 1'b0;
  endtask

  task automatic run_phase(input int p);
    foreach (tbl[i]) begin
      if (tbl[i].phase == p) begin
        while ((sidx - base) < (tbl[i].upto - (tbl[i].stb ? 1 : 0))) strobe(1'b0);
        if (tbl[i].stb) strobe(tbl[i].rd);
        else            idle(tbl[i].rd, 1'b0, 8'h00);
        check($sformatf("%s.e", tbl[i].name),    {31'd0, e_pulse},   {31'd0, tbl[i].e});
        check($sformatf("%s.l", tbl[i].name),    {31'd0, l_pulse},   {31'd0, tbl[i].l});
        check($sformatf("%s.irq", tbl[i].name),  {31'd0, frame_irq}, {31'd0, tbl[i].irq});
        check($sformatf("%s.mode", tbl[i].name), {31'd0, mode_out},  {31'd0, tbl[i].md});
      end
    end
  endtask

  initial begin
    // phase 1: 4-step frame straight out of reset, with rd_4015 races around the IRQ window
    tbl.push_back(mk(1, "p1_s1",      1,     1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, "p1_s7456",   7456,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, "p1_q7457",   7457,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, "p1_s7458",   7458,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, "p1_qh14913", 14913, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, "p1_q22371",  22371, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, "p1_s29827",  29827, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, "p1_irq_on",  29828, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, "p1_rd_clr",  29828, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, "p1_qh29829", 29829, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, "p1_rd_set",  29830, 1, 1, 0, 0, 1, 0));
    // phase 2: inhibited 4-step frame, indices from the delayed reset strobe
    tbl.push_back(mk(2, "p2_q7457",   7457,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, "p2_qh14913", 14913, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2, "p2_q22371",  22371, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, "p2_s29828",  29828, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, "p2_qh29829", 29829, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2, "p2_s29830",  29830, 1, 0, 0, 0, 0, 0));
    // phase 3: 5-step frame, indices from the delayed reset strobe
    tbl.push_back(mk(3, "p3_q7457",   7457,  1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(3, "p3_qh14913", 14913, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(3, "p3_q22371",  22371, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(3, "p3_s29828",  29828, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, "p3_s29829",  29829, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, "p3_s29830",  29830, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, "p3_s37280",  37280, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, "p3_qh37281", 37281, 1, 0, 1, 1, 0, 1));

    // reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.e",    {31'd0, e_pulse},   32'd0);
    check("rst.l",    {31'd0, l_pulse},   32'd0);
    check("rst.irq",  {31'd0, frame_irq}, 32'd0);
    check("rst.mode", {31'd0, mode_out},  32'd0);
    rst_n = 1'b1;
    sidx  = 0;
    start_phase();

    // phase 1: 4-step cadence
    run_phase(1);
    check("p1_e_count", e_cnt, 32'd4);
    check("p1_l_count", l_cnt, 32'd2);
    check("p1_wrap_cyc", {16'd0, dut.cyc}, 32'd0);

    // inhibit write with frame_irq set clears it next clk (29830 strobes so far: parity 0)
    idle(1'b0, 1'b1, 8'h40);
    check("inh_clear", {31'd0, frame_irq}, 32'd0);
    start_phase();
    repeat (3) strobe(1'b0);
    check("inh_reload_e", e_cnt, 32'd0);
    check("inh_reload_cyc", {16'd0, dut.cyc}, 32'd0);
    start_phase();
    run_phase(2);
    check("p2_e_count", e_cnt, 32'd4);
    check("p2_l_count", l_cnt, 32'd2);
    check("p2_no_irq", {31'd0, irq_seen}, 32'd0);

    // one more strobe to bring parity back to 0, then enter 5-step with a 3-strobe delay
    strobe(1'b0);
    idle(1'b0, 1'b1, 8'h80);
    start_phase();
    repeat (2) strobe(1'b0);
    check("w5_p0_s2_e",    e_cnt, 32'd0);
    check("w5_p0_s2_mode", {31'd0, mode_out}, 32'd0);
    strobe(1'b0);
    check("w5_p0_s3_e",    {31'd0, e_pulse},  32'd1);
    check("w5_p0_s3_l",    {31'd0, l_pulse},  32'd1);
    check("w5_p0_s3_mode", {31'd0, mode_out}, 32'd1);
    start_phase();
    run_phase(3);
    check("p3_e_count", e_cnt, 32'd4);
    check("p3_l_count", l_cnt, 32'd2);
    check("p3_no_irq", {31'd0, irq_seen}, 32'd0);
    strobe(1'b0);
    check("p3_wrap_cyc", {16'd0, dut.cyc}, 32'd0);
    check("p3_wrap_e",   {31'd0, e_pulse}, 32'd0);

    // parity is now 1: the same write needs 4 strobes before the reset
    idle(1'b0, 1'b1, 8'h80);
    start_phase();
    repeat (3) strobe(1'b0);
    check("w5_p1_s3_e", e_cnt, 32'd0);
    check("w5_p1_s3_l", l_cnt, 32'd0);
    strobe(1'b0);
    check("w5_p1_s4_e", {31'd0, e_pulse}, 32'd1);
    check("w5_p1_s4_l", {31'd0, l_pulse}, 32'd1);
    check("w5_p1_cyc",  {16'd0, dut.cyc}, 32'd0);

    // reset while a delay is pending: everything returns to zero and nothing fires later
    idle(1'b0, 1'b1, 8'h80);
    strobe(1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid.e",    {31'd0, e_pulse},   32'd0);
    check("rstmid.l",    {31'd0, l_pulse},   32'd0);
    check("rstmid.irq",  {31'd0, frame_irq}, 32'd0);
    check("rstmid.mode", {31'd0, mode_out},  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_phase();
    repeat (6) strobe(1'b0);
    check("rstmid_after_e",    e_cnt, 32'd0);
    check("rstmid_after_l",    l_cnt, 32'd0);
    check("rstmid_after_mode", {31'd0, mode_out}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer for the APU: counts CPU-cycle strobes and generates the envelope/linear clock (`e_pulse`) and the length/sweep clock (`l_pulse`). Both strobes feed every channel's envelope, length counter and sweep units. Also owns the $4017 mode/IRQ-inhibit register and the frame IRQ flag read through $4015. Sits in the APU top beside the register decoder; it is the producing end of the `e_pulse`/`l_pulse` interface that the pulse, triangle and noise channels consume.

## Interface
- No parameters; all step counts are fixed constants.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `apu_clk` in 1: 1-clk strobe once per CPU cycle.
- `wr_4017` in 1: 1-clk write strobe for $4017.
- `from_cpu` in 8: write data; bits [7:6] used.
- `rd_4015` in 1: 1-clk strobe when the CPU reads $4015.
- `e_pulse` out 1: quarter-frame strobe, 1 clk wide.
- `l_pulse` out 1: half-frame strobe, 1 clk wide.
- `frame_irq` out 1: frame interrupt flag, level.
- `mode_out` out 1: active sequencer mode (0 = 4-step, 1 = 5-step).

## Operation
- `cyc`: 16-bit step counter. It advances by one on each `apu_clk`, unless it wraps or is reset on that strobe.
- `parity`: 1-bit register that toggles on each `apu_clk`.
- Events are decoded from the value of `cyc` on the `apu_clk` strobe.
- Mode 0 (4-step):
  - Q (quarter frame) at 7456 and 22370.
  - Q+H (quarter and half frame) at 14912 and 29828.
  - IRQ set at 29827, 29828 and 29829, but only when `inhibit`=0.
  - At 29829, `cyc` loads 0; period is 29830.
- Mode 1 (5-step):
  - Q at 7456 and 22370.
  - Q+H at 14912 and 37280.
  - No IRQ.
  - At 37281, `cyc` loads 0; period is 37282.
- Q drives `e_pulse`; H drives `l_pulse`.
- $4017 write:
  - `inhibit` <= `from_cpu[6]` immediately. If the bit is 1, `frame_irq` clears on the next clk.
  - `pend_mode` <= `from_cpu[7]`.
  - Arms the reset delay: `dly` = 3 if `parity`=0 at the write cycle, else 4.
- Delay counting:
  - Each subsequent `apu_clk` decrements `dly`; an `apu_clk` coinciding with the write cycle is not counted.
  - On the strobe where `dly` reaches 0: `cyc` <= 0, `mode` <= `pend_mode`, delay disarmed.
  - On that same strobe, if `pend_mode`=1, Q+H fire once.
  - Normal event decode on that strobe is suppressed.
- While the delay is pending, the old `mode` keeps sequencing.
- A new write during a pending delay re-arms it with the current `parity` and replaces `pend_mode`.
- `rd_4015` clears `frame_irq`. If a set event occurs in the same clk, set wins.
- States: RUN, and PENDING (delay armed). PENDING returns to RUN on the reset strobe.

## Timing
- `e_pulse` and `l_pulse` are registered: asserted exactly one clk after the qualifying `apu_clk` strobe, for exactly 1 clk.
- `frame_irq` updates the clk after its set or clear cause.
- `mode_out` changes the clk after the reset strobe.
- Reset values: `cyc`=0, `parity`=0, `mode`=0, `pend_mode`=0, `inhibit`=0, delay disarmed.
- Reset values of outputs: `e_pulse`=0, `l_pulse`=0, `frame_irq`=0, `mode_out`=0.
- Asserting `rst_n` mid-frame or mid-delay returns to these values asynchronously. No strobe fires on the first `apu_clk` after reset release.
- `cyc` never exceeds 37281. The wrap compare is exact, not `>=`.
- `apu_clk` strobes may be spaced arbitrarily; nothing depends on the clk-per-strobe ratio.

## Test plan
- 4-step cadence: after reset, apply 29830 `apu_clk` → `e_pulse` after strobes 7457, 14913, 22371 and 29829 (1-based); `l_pulse` after 14913 and 29829; `frame_irq` rises after strobe 29828; `cyc`=0 after strobe 29830.
- IRQ clear:
  - `rd_4015` with `frame_irq`=1 and no IRQ event → `frame_irq`=0 next clk.
  - `rd_4015` coinciding with the strobe at `cyc`=29829 → `frame_irq` stays 1.
- 5-step write at `parity`=0: write `from_cpu`=0x80 → Q+H strobe after the 3rd following `apu_clk`, `mode_out`=1, and the next `l_pulse` comes 14913 strobes later; the 37281-strobe run (`cyc` 0 → 37280) never sets `frame_irq`.
- Parity delay: the same write with `parity`=1 → reset occurs after the 4th `apu_clk`.
- Inhibit: with `frame_irq`=1, write 0x40 → `frame_irq`=0 next clk; a full 4-step frame runs with no IRQ and with `e_pulse`/`l_pulse` unchanged.
- Reset mid-delay: write 0x80, then pull `rst_n` low before the delay expires → all outputs 0, `mode_out`=0, no Q+H fires after release.
